seq_mult_8x8: RTL and testbench
===============================

// Module: seq_mult_8x8
// PURPOSE
//   8x8 unsigned shift-add multiplier: one partial-product step per clock, 16-bit product.
//   Sits directly upstream of the 7-segment status decoder. state_code[2:0] drives the
//   decoder input: IDLE->0, LOAD->1, CALC->2, DONE->3. Any other code displays "E" (fault).
// PARAMETERS
//   WIDTH   8   operand width; the product is 2*WIDTH. Only 8 is verified.
//   STEPS   8   CALC iterations; must equal WIDTH.
// PORTS
//   clk         in   1   single clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   start       in   1   request to multiply; level, sampled each clk
//   dataa       in   8   multiplicand
//   datab       in   8   multiplier
//   product     out  16  result; valid while done_flag=1
//   done_flag   out  1   high in DONE
//   busy        out  1   high in LOAD or CALC
//   state_code  out  3   FSM state code, to the 7-seg decoder
// BEHAVIOUR
//   Reset (clk edge with reset=1, highest priority, any state including mid-CALC):
//     state=IDLE; state_code=3'b000; product=0; done_flag=0; busy=0; step counter=0.
//   Registers: acc[16:0] = {carry, hi[7:0], lo[7:0]}; mcand[7:0]; cnt[3:0].
//   FSM transitions, evaluated at each clk edge:
//     IDLE(000): if start=1 -> LOAD, and mcand<=dataa, acc<={9'b0,datab}, cnt<=0.
//                Otherwise stay.
//     LOAD(001): always -> CALC. One-cycle visible status; no arithmetic.
//     CALC(010): each cycle:
//                  sum = acc[0] ? {1'b0,acc[15:8]} + mcand : {1'b0,acc[15:8]};
//                  acc <= {1'b0, sum[8:0], acc[7:1]}   (shift right by one);
//                  cnt <= cnt + 1.
//                On the cycle where cnt==STEPS-1: -> DONE and product<=next acc[15:0].
//     DONE(011): done_flag=1; product held stable.
//                If start=1 -> LOAD with new operands captured, as from IDLE.
//                Otherwise stay in DONE.
//     Codes 100-111 are unreachable. If entered, next edge -> IDLE, outputs cleared.
//   Latency: start sampled high at edge k -> LOAD after k, CALC after k+1,
//     DONE with a valid product after edge k+9 (9 cycles from start).
//   start is ignored in LOAD and CALC; dataa/datab changes after capture have no effect.
//   busy and done_flag are never high together. product changes only on entry to DONE or on reset.
//   Arithmetic is unsigned. The 9-bit sum holds the carry, so no overflow is possible;
//     the maximum result is 0xFE01.
// TESTING
//   1 reset 3 cycles -> product=0x0000, state_code=000, busy=0, done_flag=0.
//   2 dataa=0x0D, datab=0x0B, start 1 cycle -> state_code 000,001,010x8,011;
//     product=0x008F at edge k+9.
//   3 dataa=0xFF, datab=0xFF -> product=0xFE01. dataa=0x00, datab=0xA5 -> 0x0000.
//   4 start pulsed and operands changed during CALC step 4 -> ignored;
//     result is that of the original operands.
//   5 reset during CALC step 5 -> IDLE next cycle, product=0. A new start then gives a correct result.
//   6 From DONE (0x0D*0x0B), start with 0x10*0x10 -> goes to LOAD; product=0x0100 nine cycles later.
//     Force state to 3'b110 -> IDLE next cycle.

Source files
------------

// File: rtl/seq_mult_8x8.sv
// Sequential 8x8 unsigned shift-add multiplier, one partial-product step per clock.
// state_code drives the 7-segment status decoder directly, so its encoding is fixed.
module seq_mult_8x8 #(
  parameter int WIDTH = 8,
  parameter int STEPS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done_flag,
  output logic                 busy,
  output logic [2:0]           state_code
);

  localparam logic [2:0] IDLE = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] CALC = 3'b010;
  localparam logic [2:0] DONE = 3'b011;

  logic [2:0]         stateQ, stateD;
  logic [2*WIDTH:0]   accQ, accD;
  logic [WIDTH-1:0]   mcandQ, mcandD;
  logic [3:0]         cntQ, cntD;
  logic [2*WIDTH-1:0] productQ, productD;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   accShift;

  // The 9-bit sum keeps the carry, so the shifted accumulator never overflows.
  always_comb begin
    sum = {1'b0, accQ[2*WIDTH-1:WIDTH]};
    if (accQ[0]) begin
      sum = sum + {1'b0, mcandQ};
    end
    accShift = {1'b0, sum, accQ[WIDTH-1:1]};
  end

  always_comb begin
    stateD   = stateQ;
    accD     = accQ;
    mcandD   = mcandQ;
    cntD     = cntQ;
    productD = productQ;
    case (stateQ)
      IDLE, DONE: begin
        if (start) begin
          stateD = LOAD;
          mcandD = dataa;
          accD   = {{(WIDTH+1){1'b0}}, datab};
          cntD   = 4'd0;
        end
      end
      LOAD: begin
        stateD = CALC;
      end
      CALC: begin
        accD = accShift;
        cntD = cntQ + 4'd1;
        if (cntQ == 4'(STEPS-1)) begin
          stateD   = DONE;
          productD = accShift[2*WIDTH-1:0];
        end
      end
      default: begin
        // Unreachable codes recover to IDLE with everything cleared.
        stateD   = IDLE;
        accD     = '0;
        mcandD   = '0;
        cntD     = 4'd0;
        productD = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= IDLE;
      accQ     <= '0;
      mcandQ   <= '0;
      cntQ     <= 4'd0;
      productQ <= '0;
    end else begin
      stateQ   <= stateD;
      accQ     <= accD;
      mcandQ   <= mcandD;
      cntQ     <= cntD;
      productQ <= productD;
    end
  end

  assign product    = productQ;
  assign done_flag  = (stateQ == DONE);
  assign busy       = (stateQ == LOAD) || (stateQ == CALC);
  assign state_code = stateQ;

endmodule

// File: tb/tb_seq_mult_8x8.sv
// Self-checking bench for seq_mult_8x8: a cycle-level phase model with plain a*b
// arithmetic is compared against the DUT on every falling edge.
module tb_seq_mult_8x8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  dataa = 8'h00;
  logic [7:0]  datab = 8'h00;
  logic [15:0] product;
  logic        done_flag;
  logic        busy;
  logic [2:0]  state_code;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;
  bit injectIllegal = 1'b0;

  int          expCode = 0;
  int          stepsLeft = 0;
  logic [15:0] expProduct = 16'h0000;
  logic [7:0]  opA = 8'h00;
  logic [7:0]  opB = 8'h00;

  seq_mult_8x8 dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dataa      (dataa),
    .datab      (datab),
    .product    (product),
    .done_flag  (done_flag),
    .busy       (busy),
    .state_code (state_code)
  );

  always #5 clk = ~clk;

  // Phase model: 0 idle, 1 load, 2 calc (eight cycles), 3 done; result is plain a*b.
  always @(posedge clk) begin
    if (reset) begin
      expCode    = 0;
      expProduct = 16'h0000;
    end else if (injectIllegal) begin
      expCode    = 0;
      expProduct = 16'h0000;
    end else begin
      case (expCode)
        0, 3: if (start) begin
          expCode = 1;
          opA     = dataa;
          opB     = datab;
        end
        1: begin
          expCode   = 2;
          stepsLeft = 8;
        end
        default: begin
          stepsLeft = stepsLeft - 1;
          if (stepsLeft == 0) begin
            expCode    = 3;
            expProduct = {8'h00, opA} * {8'h00, opB};
          end
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] eCode;
    if (checkEn) begin
      eCode = injectIllegal ? 3'b110 : 3'(expCode);
      check("state_code", {13'd0, state_code}, {13'd0, eCode});
      check("busy", {15'd0, busy}, {15'd0, (eCode == 3'd1) || (eCode == 3'd2)});
      check("done_flag", {15'd0, done_flag}, {15'd0, eCode == 3'd3});
      check("product", product, expProduct);
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    #1;
    dataa = a;
    datab = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done_flag; a negative expLatency skips the latency check.
  task automatic checkOutput(input string name, input logic [15:0] exp, input int expLatency);
    int n = 0;
    while (!done_flag && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (expLatency >= 0) check({name, " latency"}, 16'(n), 16'(expLatency));
    else check({name, " timeout"}, {15'd0, done_flag}, 16'd1);
    check(name, product, exp);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    checkEn = 1'b1;
    check("reset product", product, 16'h0000);
    check("reset state_code", {13'd0, state_code}, 16'd0);
    check("reset busy", {15'd0, busy}, 16'd0);
    check("reset done_flag", {15'd0, done_flag}, 16'd0);
    reset = 1'b0;

    applyStimulus(8'h0D, 8'h0B);
    check("load after start", {13'd0, state_code}, 16'd1);
    checkOutput("0x0D*0x0B", 16'h008F, 9);
    check("model 0x0D*0x0B", expProduct, 16'h008F);

    applyStimulus(8'hFF, 8'hFF);
    checkOutput("0xFF*0xFF", 16'hFE01, 9);
    applyStimulus(8'h00, 8'hA5);
    checkOutput("0x00*0xA5", 16'h0000, 9);

    // start and operand changes mid-CALC must be ignored
    applyStimulus(8'h37, 8'h5A);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    dataa = 8'hC3;
    datab = 8'h7E;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ignore start in CALC", 16'h1356, -1);

    applyStimulus(8'h21, 8'h42);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset mid-CALC state", {13'd0, state_code}, 16'd0);
    check("reset mid-CALC product", product, 16'h0000);
    applyStimulus(8'h21, 8'h42);
    checkOutput("after reset 0x21*0x42", 16'h0882, 9);

    applyStimulus(8'h0D, 8'h0B);
    checkOutput("0x0D*0x0B again", 16'h008F, 9);
    applyStimulus(8'h10, 8'h10);
    check("DONE to LOAD", {13'd0, state_code}, 16'd1);
    checkOutput("0x10*0x10 from DONE", 16'h0100, 9);

    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 4 == 0) a = 8'hFF;
      applyStimulus(a, b);
      dataa = 8'($urandom);
      datab = 8'($urandom);
      checkOutput("random", {8'h00, a} * {8'h00, b}, 9);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(posedge clk);
    #1;
    injectIllegal = 1'b1;
    force dut.stateQ = 3'b110;
    #1;
    release dut.stateQ;
    @(posedge clk);
    #1;
    injectIllegal = 1'b0;
    check("illegal state recovery", {13'd0, state_code}, 16'd0);
    check("illegal state product", product, 16'h0000);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
